fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have ports: clk input 1 rising-edge clock; rst_n input 1 reset, asynchronous and active-low.
REQ-005 SHALL have ports: imem_req_valid output 1; imem_req_ready input 1; imem_req_addr output DATA_WIDTH.
REQ-006 SHALL have ports: imem_rsp_valid input 1; imem_rsp_data input DATA_WIDTH (responses in request order).
REQ-007 SHALL have ports: Instr output DATA_WIDTH; PC output DATA_WIDTH; instr_valid output 1; instr_ready input 1 (decode/sign-extend side).
REQ-008 SHALL have ports: redirect_valid input 1; redirect_pc input DATA_WIDTH (branch/jump target).

Function
REQ-009 SHALL hold fetch PC register; allocate a queue entry (storing PC) on each request handshake (imem_req_valid && imem_req_ready); PC += 4 on handshake.
REQ-010 SHALL assert imem_req_valid only in state FETCH with allocated entries < DEPTH; imem_req_valid SHALL NOT depend combinationally on redirect_valid.
REQ-011 SHALL keep imem_req_addr == fetch PC, stable while imem_req_valid && !imem_req_ready.
REQ-012 SHALL fill the oldest allocated-unfilled entry with imem_rsp_data on imem_rsp_valid (state FETCH).
REQ-013 SHALL drive instr_valid=1 when head entry is filled; Instr/PC = head data/PC; pop on instr_valid && instr_ready.
REQ-014 SHALL allow alloc, fill and pop in the same cycle; a response filling an empty-head entry becomes visible on instr_valid the following cycle (1-cycle latency).
REQ-015 SHALL implement states FETCH and FLUSH; redirect_valid in any state: clear all entries, fetch PC <= redirect_pc, discard_cnt <= unfilled in-flight count (including any request handshaking this cycle) minus imem_rsp_valid this cycle, next state FLUSH if that result > 0 else FETCH.
REQ-016 SHALL, in FLUSH, drop every response and decrement discard_cnt; FLUSH -> FETCH when discard_cnt reaches 0; no requests issued in FLUSH.
REQ-017 SHALL give redirect priority over pop: instr_ready in redirect cycle does not count as consumption (entry discarded).
REQ-018 SHALL ignore imem_rsp_valid with no in-flight request (no state change).

Reset
REQ-019 SHALL on rst_n low asynchronously set: state FETCH, fetch PC=RESET_PC, all pointers/counts 0, instr_valid=0, imem_req_valid=0, Instr=0, PC=0.
REQ-020 SHALL issue first request (address RESET_PC) no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-021 SHALL support macro FETCH_MISALIGN_CHECK_EN: when defined, add output misaligned (1 bit) and state HALT; redirect with redirect_pc[1:0]!=0 enters HALT (after FLUSH drain), sets misaligned=1, stops requests until next aligned redirect; when undefined, redirect_pc[1:0] ignored (forced to 00), no misaligned port.

Structure
REQ-022 SHALL place state enum (FETCH, FLUSH, HALT) and PC_STEP=4 in shared package fetch_pkg.
REQ-023 SHALL be a single module, no sub-modules; queue storage is an internal array with alloc/fill/read pointers of $clog2(DEPTH)+1 bits for wrap detection.

Verification
REQ-024 Reset, imem_req_ready=1, 1-cycle response, instr_ready=1 -> addrs 0x0,0x4,0x8...; instr_valid with PC=0x0 then consecutive words, no gaps.
REQ-025 instr_ready=0, DEPTH=4 -> exactly 4 handshakes (0x0..0xC), imem_req_valid low; one pop -> one request at 0x10.
REQ-026 imem_req_ready=0 for 5 cycles -> imem_req_addr held 0x0, valid held high.
REQ-027 Redirect to 0x100 with 3 responses in flight -> next 3 responses dropped, no instr_valid, then requests at 0x100, first Instr has PC=0x100.
REQ-028 Redirect and imem_rsp_valid and instr_ready in same cycle with 2 in flight -> discard_cnt=1; head not popped; next Instr PC=redirect_pc.
REQ-029 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> misaligned=1, no requests; redirect to 0x200 -> misaligned=0, fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH,
      FLUSH,
      HALT
   } fetch_state_e;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: issues imem requests, buffers responses, feeds decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a misaligned flag and HALT state.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic [DATA_WIDTH-1:0] Instr,
   output logic [DATA_WIDTH-1:0] PC,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic                  misaligned
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [DATA_WIDTH-1:0] pc_q   [DEPTH];

   fetch_state_e          state;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [PW-1:0]         alloc_ptr;
   logic [PW-1:0]         fill_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         discard_cnt;
   logic                  run;
   logic                  halt_pend;

   logic [PW-1:0]         used;
   logic [PW-1:0]         unfilled;
   logic [PW-1:0]         inflight;
   logic [PW-1:0]         inflight_nxt;
   logic                  req_hs;
   logic                  rsp_take;
   logic                  fill_en;
   logic                  pop;
   logic                  mis;
   logic [DATA_WIDTH-1:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign mis    = redirect_pc[1:0] != 2'b00;
   assign target = redirect_pc;
`else
   assign mis    = 1'b0;
   assign target = redirect_pc & ~(DATA_WIDTH'(3));
`endif

   assign used     = alloc_ptr - rd_ptr;
   assign unfilled = alloc_ptr - fill_ptr;

   // run holds requests off until the first edge after reset release
   assign imem_req_valid = run && (state == FETCH)
                        && (used < PW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_hs         = imem_req_valid && imem_req_ready;

   assign instr_valid = fill_ptr != rd_ptr;
   assign Instr = instr_valid ? data_q[rd_ptr[AW-1:0]] : '0;
   assign PC    = instr_valid ? pc_q[rd_ptr[AW-1:0]]   : '0;
   assign pop   = instr_valid && instr_ready && !redirect_valid;

   // in FLUSH the entries are gone; only the discard count tracks flight
   assign inflight     = (state == FLUSH) ? discard_cnt : unfilled;
   assign rsp_take     = imem_rsp_valid && (inflight != '0);
   assign inflight_nxt = inflight + PW'(req_hs) - PW'(rsp_take);
   assign fill_en      = (state == FETCH) && rsp_take && !redirect_valid;

   always_ff @(posedge clk) begin
      if (req_hs)
         pc_q[alloc_ptr[AW-1:0]] <= fetch_pc;
      if (fill_en)
         data_q[fill_ptr[AW-1:0]] <= imem_rsp_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         alloc_ptr   <= '0;
         fill_ptr    <= '0;
         rd_ptr      <= '0;
         discard_cnt <= '0;
         run         <= 1'b0;
         halt_pend   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         misaligned  <= 1'b0;
`endif
      end else begin
         run <= 1'b1;
         if (redirect_valid) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            fetch_pc    <= target;
            discard_cnt <= inflight_nxt;
            halt_pend   <= mis;
`ifdef FETCH_MISALIGN_CHECK_EN
            misaligned  <= mis;
`endif
            if (inflight_nxt != '0)
               state <= FLUSH;
            else if (mis)
               state <= HALT;
            else
               state <= FETCH;
         end else begin
            if (req_hs) begin
               alloc_ptr <= alloc_ptr + 1'b1;
               fetch_pc  <= fetch_pc + DATA_WIDTH'(PC_STEP);
            end
            if (fill_en)
               fill_ptr <= fill_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (state == FLUSH && rsp_take) begin
               discard_cnt <= discard_cnt - 1'b1;
               if (discard_cnt == PW'(1))
                  state <= halt_pend ? HALT : FETCH;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a program-order reference model.
// Model: pending request list with stale tags, plus a ready-instruction list.
module tb_fetch_queue;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misaligned;
`endif

   fetch_queue #(
      .DATA_WIDTH(32),
      .DEPTH(4),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .Instr(Instr),
      .PC(PC),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .misaligned(misaligned)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] rdyq[$];
   logic [31:0] exp_addr;
   logic [31:0] first_pc;
   bit          run_m;
   bit          halt_m;
   int          nhs;
   int          npop;
   int          tests;
   int          fails;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   function automatic int n_fresh();
      int n = 0;
      foreach (pend[i]) if (!pend[i].stale) n++;
      return n;
   endfunction

   function automatic bit any_stale();
      foreach (pend[i]) if (pend[i].stale) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #1;
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instr", Instr, 0);
      check("rst_pc", PC, 0);
      check("rst_req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misaligned", misaligned, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      pend.delete();
      rdyq.delete();
      exp_addr = 32'h0;
      run_m    = 1'b0;
      halt_m   = 1'b0;
      nhs      = 0;
      npop     = 0;
      first_pc = 32'hFFFF_FFFF;
   endtask

   // One cycle: check outputs, drive inputs, advance the model, clock.
   task automatic step(input bit redir, input logic [31:0] tgt,
                       input bit rq, input bit ir, input bit rs);
      bit    ev;
      bit    hs;
      bit    took;
      pend_t e;
      e  = '{addr: 32'h0, stale: 1'b0};
      ev = run_m && !halt_m && !any_stale()
        && (n_fresh() + rdyq.size() < 4);
      check("req_valid", imem_req_valid, ev);
      if (imem_req_valid)
         check("req_addr", imem_req_addr, exp_addr);
      check("instr_valid", instr_valid, rdyq.size() != 0);
      if (rdyq.size() != 0) begin
         check("pc", PC, rdyq[0]);
         check("instr", Instr, memf(rdyq[0]));
      end
      redirect_valid = redir;
      redirect_pc    = tgt;
      imem_req_ready = rq;
      instr_ready    = ir;
      imem_rsp_valid = rs;
      took = rs && pend.size() != 0;
      if (took) begin
         e = pend.pop_front();
         imem_rsp_data = memf(e.addr);
      end else begin
         imem_rsp_data = $urandom;
      end
      hs = ev && rq;
      if (rdyq.size() != 0 && ir && !redir) begin
         if (npop == 0) first_pc = rdyq[0];
         void'(rdyq.pop_front());
         npop++;
      end
      if (took && !e.stale && !redir)
         rdyq.push_back(e.addr);
      if (hs) begin
         pend.push_back('{addr: exp_addr, stale: 1'b0});
         exp_addr = exp_addr + 32'd4;
         nhs++;
      end
      if (redir) begin
         rdyq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
         exp_addr = tgt;
         halt_m   = tgt[1:0] != 2'b00;
`else
         exp_addr = tgt & ~32'd3;
`endif
      end
      @(posedge clk);
      run_m = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;

      // streaming with full throughput
      do_reset();
      repeat (16) step(0, 0, 1, 1, 1);
      check("stream_hs", nhs, 15);
      check("stream_pops", npop, 13);
      check("stream_first_pc", first_pc, 32'h0);

      // decode stalled: queue fills to DEPTH, then one pop frees a slot
      do_reset();
      repeat (10) step(0, 0, 1, 0, 1);
      check("full_hs", nhs, 4);
      check("full_next_addr", exp_addr, 32'h10);
      step(0, 0, 1, 1, 1);
      repeat (3) step(0, 0, 1, 0, 1);
      check("after_pop_hs", nhs, 5);

      // memory not ready: address held
      do_reset();
      repeat (6) step(0, 0, 0, 1, 1);
      check("stall_hs", nhs, 0);
      repeat (4) step(0, 0, 1, 1, 1);

      // redirect with three requests in flight
      do_reset();
      repeat (4) step(0, 0, 1, 1, 0);
      step(1, 32'h100, 0, 1, 0);
      npop = 0;
      repeat (12) step(0, 0, 1, 1, 1);
      check("redir_pops_nz", npop != 0, 1);
      check("redir_first_pc", first_pc, 32'h100);

      // redirect + response + instr_ready together, two unfilled
      do_reset();
      repeat (4) step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      check("pre_redir_valid", instr_valid, 1);
      npop = 0;
      step(1, 32'h300, 0, 1, 1);
      check("redir_no_pop", npop, 0);
      repeat (10) step(0, 0, 1, 1, 1);
      check("redir2_first_pc", first_pc, 32'h300);

`ifdef FETCH_MISALIGN_CHECK_EN
      do_reset();
      repeat (3) step(0, 0, 1, 1, 0);
      step(1, 32'h102, 0, 1, 0);
      repeat (6) step(0, 0, 1, 1, 1);
      check("mis_set", misaligned, 1);
      npop = 0;
      step(1, 32'h200, 0, 1, 0);
      check("mis_clr", misaligned, 0);
      repeat (8) step(0, 0, 1, 1, 1);
      check("mis_resume_pc", first_pc, 32'h200);
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit          rd;
         logic [31:0] t;
         rd = $urandom_range(0, 24) == 0;
         t  = $urandom & 32'h0000_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
         if ($urandom_range(0, 7) == 0)
            t[1:0] = 2'($urandom_range(1, 3));
`endif
         step(rd, t, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
      check("rand_progress", npop > 100, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
